tb_ctrl_periph: RTL

TB_CTRL_PERIPH -- requirements
Module: tb_ctrl_periph

---
 rtl/tb_ctrl_pkg.sv | 41 ++++
 rtl/tb_ctrl_periph_if.sv | 23 ++
 rtl/tb_ctrl_fifo.sv | 58 +++++
 rtl/tb_ctrl_periph.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/tb_ctrl_pkg.sv
// Shared definitions for the testbench control peripheral.
//   - register offsets inside the 256-byte window
//   - default pass code for TEST_STATUS
//   - bus request struct and controller state type
//   - apply_be(): byte-lane merge used by read-modify-write registers
package tb_ctrl_pkg;

    localparam logic [31:0] PASS_CODE_DEFAULT = 32'd123456789;
    localparam logic [31:0] FAIL_CODE         = 32'd1;

    localparam logic [7:0] OFF_STDOUT      = 8'h00;
    localparam logic [7:0] OFF_TEST_STATUS = 8'h04;
    localparam logic [7:0] OFF_EXIT        = 8'h08;
    localparam logic [7:0] OFF_TIMER_CTRL  = 8'h0C;
    localparam logic [7:0] OFF_TIMER_CNT   = 8'h10;
    localparam logic [7:0] OFF_TIMER_CMP   = 8'h14;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [7:0]  off;
        logic [31:0] wdata;
    } bus_req_t;

    // One response slot: RESP means a response is presented this cycle.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } ctrl_state_t;

    function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/tb_ctrl_periph_if.sv
// Data-bus interface of the control peripheral.
//   master: drives req_i/we_i/be_i/addr_i/wdata_i, receives gnt_o/rvalid_o/rdata_o
//   slave : the peripheral side
interface tb_ctrl_periph_if;
    logic        req_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/tb_ctrl_fifo.sv
// Synchronous FIFO for the stdout character stream.
//   clk, rst_n        : clock, asynchronous active-low reset
//   push, push_data   : write one entry (ignored when full)
//   pop               : remove head entry (ignored when empty)
//   head              : current head entry, valid while !empty
//   empty, full, count: occupancy, count is $clog2(DEPTH)+1 bits
// DEPTH must be a power of two so the pointers wrap naturally.
module tb_ctrl_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: storage has no reset; entries are only observed once the count says they are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: state registers use <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tb_ctrl_periph.sv
// Testbench control peripheral: stdout FIFO, test status, exit request, timer.
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus          : data bus (slave modport), one response per grant, one cycle later
//   char_*       : stdout byte stream, valid/ready
//   tests_*_o    : one-cycle pass/fail pulses
//   exit_*       : exit pulse and held exit code
//   timer_irq_o  : level interrupt when the enabled counter meets the compare value
module tb_ctrl_periph
    import tb_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int unsigned STDOUT_DEPTH = 16,
    parameter logic [31:0] PASS_CODE    = PASS_CODE_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    tb_ctrl_periph_if.slave bus,
    output logic            char_valid_o,
    output logic [7:0]      char_o,
    input  logic            char_ready_i,
    output logic            tests_passed_o,
    output logic            tests_failed_o,
    output logic            exit_valid_o,
    output logic [31:0]     exit_value_o,
    output logic            timer_irq_o
);
    localparam int unsigned CNT_W = $clog2(STDOUT_DEPTH) + 1;

    bus_req_t         breq;
    logic             fifo_empty, fifo_full, fifo_pop, fifo_push;
    logic [CNT_W-1:0] fifo_count;
    logic             gnt, wr_en;
    logic             wr_stdout, wr_status, wr_exit, wr_ctrl, wr_cnt, wr_cmp;
    logic             timer_en;
    logic [31:0]      timer_cnt, timer_cmp, rd_value, rdata_q;
    ctrl_state_t      state_q, state_d;

    assign breq = '{we: bus.we_i, be: bus.be_i, off: bus.addr_i[7:0], wdata: bus.wdata_i};

    // Full is derived from the registered count, so char_ready_i has no path to gnt.
    // A pop in the same cycle therefore does not unblock a stalled write.
    assign gnt = rst_n && bus.req_i && !(breq.we && (breq.off == OFF_STDOUT) && fifo_full);
    assign wr_en = gnt && breq.we;

    assign wr_stdout = wr_en && (breq.off == OFF_STDOUT);
    assign wr_status = wr_en && (breq.off == OFF_TEST_STATUS);
    assign wr_exit   = wr_en && (breq.off == OFF_EXIT);
    assign wr_ctrl   = wr_en && (breq.off == OFF_TIMER_CTRL);
    assign wr_cnt    = wr_en && (breq.off == OFF_TIMER_CNT);
    assign wr_cmp    = wr_en && (breq.off == OFF_TIMER_CMP);

    assign fifo_push    = wr_stdout && breq.be[0];
    assign char_valid_o = !fifo_empty;
    assign fifo_pop     = char_valid_o && char_ready_i;

    tb_ctrl_fifo #(.DEPTH(STDOUT_DEPTH), .WIDTH(8)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (breq.wdata[7:0]),
        .pop       (fifo_pop),
        .head      (char_o),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    always_comb begin
        // NOTE: assigning a default first means every path drives rd_value, so no latch is inferred.
        rd_value = '0;
        case (breq.off)
            OFF_STDOUT:     rd_value = 32'(fifo_count);
            OFF_TIMER_CTRL: rd_value = {31'b0, timer_en};
            OFF_TIMER_CNT:  rd_value = timer_cnt;
            OFF_TIMER_CMP:  rd_value = timer_cmp;
            default:        rd_value = '0;
        endcase
    end

    // A grant in either state books the response slot for the next cycle.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: if (gnt) state_d = ST_RESP;
            ST_RESP: if (gnt) state_d = ST_RESP;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= (gnt && !breq.we) ? rd_value : '0;
        end
    end

    assign bus.gnt_o    = gnt;
    assign bus.rvalid_o = (state_q == ST_RESP);
    assign bus.rdata_o  = rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tests_passed_o <= 1'b0;
            tests_failed_o <= 1'b0;
            exit_valid_o   <= 1'b0;
            exit_value_o   <= '0;
        end else begin
            tests_passed_o <= wr_status && (breq.wdata == PASS_CODE);
            tests_failed_o <= wr_status && (breq.wdata == FAIL_CODE);
            exit_valid_o   <= wr_exit;
            if (wr_exit) exit_value_o <= apply_be(exit_value_o, breq.wdata, breq.be);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_en    <= 1'b0;
            timer_cnt   <= '0;
            timer_cmp   <= 32'hFFFF_FFFF;
            timer_irq_o <= 1'b0;
        end else begin
            if (wr_ctrl && breq.be[0]) timer_en <= breq.wdata[0];
            if (wr_cmp) timer_cmp <= apply_be(timer_cmp, breq.wdata, breq.be);
            // Software write takes priority over the free-running increment.
            if (wr_cnt) begin
                timer_cnt <= apply_be(timer_cnt, breq.wdata, breq.be);
            end else if (timer_en) begin
                timer_cnt <= timer_cnt + 32'd1;
            end
            // Any CTRL/CMP write clears the interrupt, even on a match cycle.
            if (wr_ctrl || wr_cmp) begin
                timer_irq_o <= 1'b0;
            end else if (timer_en && (timer_cnt == timer_cmp)) begin
                timer_irq_o <= 1'b1;
            end
        end
    end

    // Requests arrive already decoded; an out-of-window address is a system error.
    a_in_window: assert property (@(posedge clk) disable iff (!rst_n)
        bus.req_i |-> (bus.addr_i[31:8] == BASE_ADDR[31:8]));

endmodule
